// File: rtl/lsu_mem_initiator.sv
// Purpose: load/store initiator between the MEM stage and the data-memory bus.
// Latency: store with immediate gnt responds 2 cycles after accept; a load with rvalid right after gnt responds in 3 cycles.
// Backpressure: req_ready only in IDLE; the bus stalls via gnt/rvalid under a watchdog; responses cannot be stalled.
//
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready        pipeline request handshake (ready only in IDLE)
//   req_we, req_op, req_addr,  store flag, {zero_ext, size[1:0]}, byte address,
//   req_wdata                  store data (low bits significant)
//   rsp_valid/rsp_data/rsp_err one-cycle response pulse, extended load data, error
//   mem_req/mem_we/mem_addr/   word-addressed bus request with byte enables and
//   mem_be/mem_wdata           lane-replicated write data
//   mem_gnt, mem_rvalid,       bus accept strobe, read-data strobe and read word
//   mem_rdata
module lsu_mem_initiator #(
    parameter int TIMEOUT = 16,     // max cycles in REQ or WAIT_R, >= 2
    parameter int CNT_W   = 5       // 2**CNT_W must exceed TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;

    // The counter holds (cycles already spent in the state - 1), so the
    // limit is hit during the TIMEOUT-th cycle of REQ or WAIT_R.
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q;
    logic [2:0]       op_q;
    logic [31:0]      addr_q;
    logic [3:0]       be_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;

    logic             accept;
    logic             misaligned;
    logic             at_limit;
    logic [3:0]       be_in;
    logic [31:0]      wdata_in;
    logic [31:0]      lane_shift;
    logic [31:0]      load_ext;

    assign accept   = req_valid && (state_q == IDLE);
    assign at_limit = (cnt_q == LIMIT);

    // Alignment check and bus lane preparation on the incoming request.
    always_comb begin
        misaligned = 1'b0;
        be_in      = 4'b0000;
        wdata_in   = 32'h0;
        case (req_op[1:0])
            2'b00: begin
                be_in    = 4'b0001 << req_addr[1:0];
                wdata_in = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = req_addr[0];
                be_in      = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_in   = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                misaligned = |req_addr[1:0];
                be_in      = 4'b1111;
                wdata_in   = req_wdata;
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

    // Shift the addressed lane down to bit 0; aligned halves/words shift by
    // 0 or 16 / 0, so one barrel shift covers every size.
    assign lane_shift = mem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_ext = lane_shift;
        case (op_q[1:0])
            2'b00:   load_ext = op_q[2] ? {24'h0, lane_shift[7:0]}
                                        : {{24{lane_shift[7]}}, lane_shift[7:0]};
            2'b01:   load_ext = op_q[2] ? {16'h0, lane_shift[15:0]}
                                        : {{16{lane_shift[15]}}, lane_shift[15:0]};
            default: load_ext = lane_shift;
        endcase
    end

    // Next-state logic. A gnt/rvalid in the limit cycle takes priority over
    // the timeout.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        state_d    = RESP;
                        rsp_err_d  = 1'b1;
                        rsp_data_d = 32'h0;
                    end else begin
                        state_d = REQ;
                        cnt_d   = '0;
                    end
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    if (we_q) begin
                        state_d    = RESP;
                        rsp_err_d  = 1'b0;
                        rsp_data_d = 32'h0;
                    end else begin
                        state_d = WAIT_R;
                        cnt_d   = '0;
                    end
                end else if (at_limit) begin
                    state_d    = RESP;
                    rsp_err_d  = 1'b1;
                    rsp_data_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_R: begin
                if (mem_rvalid) begin
                    state_d    = RESP;
                    rsp_err_d  = 1'b0;
                    rsp_data_d = load_ext;
                end else if (at_limit) begin
                    state_d    = RESP;
                    rsp_err_d  = 1'b1;
                    rsp_data_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rsp_data_q <= 32'h0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Request fields are captured once at accept so the bus sees stable
    // values for the whole time mem_req is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q    <= 1'b0;
            op_q    <= 3'b000;
            addr_q  <= 32'h0;
            be_q    <= 4'b0000;
            wdata_q <= 32'h0;
        end else if (accept) begin
            we_q    <= req_we;
            op_q    <= req_op;
            addr_q  <= req_addr;
            be_q    <= be_in;
            wdata_q <= wdata_in;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign mem_req   = (state_q == REQ);
    assign mem_we    = we_q;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
module tb_lsu_mem_initiator;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lsu_mem_initiator #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    // Advance one clock; everything after returns 1 time unit past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; on return the accept edge has passed.
    task automatic issue(input logic we, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1; req_we = we; req_op = op; req_addr = a; req_wdata = d;
        step();
        req_valid = 1'b0;
    endtask

    // Load with gnt in the first REQ cycle and rvalid the cycle after.
    task automatic run_load(input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] rd, output logic [3:0] be,
                            output logic v, output logic e, output logic [31:0] d);
        issue(1'b0, op, a, 32'h0);
        be = mem_be;
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = rd;
        step();
        mem_rvalid = 1'b0;
        v = rsp_valid; e = rsp_err; d = rsp_data;
        step();
    endtask

    task automatic test_reset();
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        checks++; if ({mem_req, rsp_valid, rsp_err} !== 3'b000) begin errors++; $display("FAIL reset_strobes got=%b exp=000", {mem_req, rsp_valid, rsp_err}); end
        checks++; if ({rsp_data, mem_be, mem_addr} !== 68'h0) begin errors++; $display("FAIL reset_regs got=%h exp=0", {rsp_data, mem_be, mem_addr}); end
        step(); step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_word_store();
        issue(1'b1, 3'b010, 32'd12, 32'h3B800001);
        checks++; if ({mem_req, mem_we, req_ready} !== 3'b110) begin errors++; $display("FAIL wst_req got=%b exp=110", {mem_req, mem_we, req_ready}); end
        checks++; if (mem_addr !== 32'd12) begin errors++; $display("FAIL wst_addr got=%h exp=%h", mem_addr, 32'd12); end
        checks++; if (mem_be !== 4'b1111) begin errors++; $display("FAIL wst_be got=%b exp=1111", mem_be); end
        checks++; if (mem_wdata !== 32'h3B800001) begin errors++; $display("FAIL wst_wdata got=%h exp=3b800001", mem_wdata); end
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        checks++; if ({rsp_valid, rsp_err, mem_req} !== 3'b100) begin errors++; $display("FAIL wst_rsp got=%b exp=100", {rsp_valid, rsp_err, mem_req}); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL wst_rdata got=%h exp=0", rsp_data); end
        step();
        checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL wst_after got=%b exp=01", {rsp_valid, req_ready}); end
    endtask

    task automatic test_byte();
        logic [3:0] be; logic v, e; logic [31:0] d;
        issue(1'b1, 3'b000, 32'd13, 32'h00015B38);
        checks++; if (mem_be !== 4'b0010) begin errors++; $display("FAIL bst_be got=%b exp=0010", mem_be); end
        checks++; if (mem_wdata !== 32'h38383838) begin errors++; $display("FAIL bst_wdata got=%h exp=38383838", mem_wdata); end
        checks++; if (mem_addr !== 32'd12) begin errors++; $display("FAIL bst_addr got=%h exp=0000000c", mem_addr); end
        mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
        checks++; if ({rsp_valid, rsp_err} !== 2'b10) begin errors++; $display("FAIL bst_rsp got=%b exp=10", {rsp_valid, rsp_err}); end
        step();
        run_load(3'b000, 32'd13, 32'h00003800, be, v, e, d);
        checks++; if ({be, v, e} !== 6'b0010_10) begin errors++; $display("FAIL bld13_ctl got=%b exp=001010", {be, v, e}); end
        checks++; if (d !== 32'h00000038) begin errors++; $display("FAIL bld13_data got=%h exp=00000038", d); end
        run_load(3'b000, 32'd12, 32'h00000080, be, v, e, d);
        checks++; if ({be, v, e} !== 6'b0001_10) begin errors++; $display("FAIL bld12_ctl got=%b exp=000110", {be, v, e}); end
        checks++; if (d !== 32'hFFFFFF80) begin errors++; $display("FAIL bld12_data got=%h exp=ffffff80", d); end
    endtask

    task automatic test_half();
        logic [3:0] be; logic v, e; logic [31:0] d;
        run_load(3'b101, 32'd1022, 32'h80011234, be, v, e, d);
        checks++; if ({be, v, e} !== 6'b1100_10) begin errors++; $display("FAIL hldu_ctl got=%b exp=110010", {be, v, e}); end
        checks++; if (d !== 32'h00008001) begin errors++; $display("FAIL hldu_data got=%h exp=00008001", d); end
        run_load(3'b001, 32'd1022, 32'h80011234, be, v, e, d);
        checks++; if (d !== 32'hFFFF8001) begin errors++; $display("FAIL hlds_data got=%h exp=ffff8001", d); end
    endtask

    task automatic test_misaligned();
        logic [3:0] be; logic v, e; logic [31:0] d;
        issue(1'b0, 3'b010, 32'd13, 32'h0);
        checks++; if ({mem_req, rsp_valid, rsp_err} !== 3'b011) begin errors++; $display("FAIL mis_word got=%b exp=011", {mem_req, rsp_valid, rsp_err}); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL mis_word_data got=%h exp=0", rsp_data); end
        step();
        checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL mis_after got=%b exp=01", {rsp_valid, req_ready}); end
        run_load(3'b000, 32'd12, 32'h00000080, be, v, e, d);
        issue(1'b0, 3'b011, 32'd0, 32'h0);
        checks++; if ({mem_req, rsp_valid, rsp_err} !== 3'b011) begin errors++; $display("FAIL mis_size got=%b exp=011", {mem_req, rsp_valid, rsp_err}); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL mis_size_data got=%h exp=0", rsp_data); end
        step();
    endtask

    task automatic test_gnt_delay();
        int stable = 0;
        issue(1'b1, 3'b001, 32'h102, 32'hABCD1234);
        for (int i = 0; i < 3; i++) begin
            if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata} === {2'b11, 32'h100, 4'b1100, 32'h12341234})
                stable++;
            step();
        end
        checks++; if (stable !== 3) begin errors++; $display("FAIL gdly_stable got=%0d exp=3", stable); end
        checks++; if ({mem_req, rsp_valid} !== 2'b10) begin errors++; $display("FAIL gdly_wait got=%b exp=10", {mem_req, rsp_valid}); end
        mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
        checks++; if ({rsp_valid, rsp_err, mem_req} !== 3'b100) begin errors++; $display("FAIL gdly_rsp got=%b exp=100", {rsp_valid, rsp_err, mem_req}); end
        step();
    endtask

    task automatic test_timeout();
        int n = 0;
        issue(1'b1, 3'b010, 32'h200, 32'h5);
        while (mem_req === 1'b1 && n < 40) begin
            n++;
            step();
        end
        checks++; if (n !== 16) begin errors++; $display("FAIL tmo_cycles got=%0d exp=16", n); end
        checks++; if ({rsp_valid, rsp_err} !== 2'b11) begin errors++; $display("FAIL tmo_rsp got=%b exp=11", {rsp_valid, rsp_err}); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL tmo_data got=%h exp=0", rsp_data); end
        step();
        // Grant in the very last allowed cycle must complete normally.
        issue(1'b1, 3'b010, 32'h204, 32'h6);
        repeat (15) step();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL tmo16_req got=%b exp=1", mem_req); end
        mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
        checks++; if ({rsp_valid, rsp_err} !== 2'b10) begin errors++; $display("FAIL tmo16_rsp got=%b exp=10", {rsp_valid, rsp_err}); end
        step();
    endtask

    task automatic test_reset_mid();
        logic [3:0] be; logic v, e; logic [31:0] d;
        int seen = 0;
        issue(1'b0, 3'b010, 32'h40, 32'h0);
        mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
        checks++; if ({req_ready, mem_req} !== 2'b00) begin errors++; $display("FAIL rmid_wait got=%b exp=00", {req_ready, mem_req}); end
        #2 reset = 1'b0;
        #1;
        checks++; if ({mem_req, rsp_valid, req_ready} !== 3'b001) begin errors++; $display("FAIL rmid_async got=%b exp=001", {mem_req, rsp_valid, req_ready}); end
        step();
        reset = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        step();
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (rsp_valid !== 1'b0) seen++;
            step();
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rmid_late_rvalid got=%0d exp=0", seen); end
        run_load(3'b000, 32'd12, 32'h00000080, be, v, e, d);
        checks++; if ({v, e, d} !== {2'b10, 32'hFFFFFF80}) begin errors++; $display("FAIL rmid_after got=%b%b %h exp=10 ffffff80", v, e, d); end
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_op = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        test_reset();
        test_word_store();
        test_byte();
        test_half();
        test_misaligned();
        test_gnt_delay();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
